// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO for byte streams between the
// processor and board peripherals.
// Read mode is selected by SHOWAHEAD (0 = registered q, 1 = show-ahead q).
// Define SYNC_FIFO_STATUS_EN to build the overflow/underflow sticky flags and
// the almost_full comparator. Without it, those three outputs are tied low.
// The accept/reject rules for reads and writes are the same in both builds.
module sync_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH_LOG2  = 4,
    parameter int AFULL_LEVEL = 12,
    parameter int SHOWAHEAD   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [WIDTH-1:0]      q,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   usedw,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  rd_acc;
    logic                  wr_acc;

    // Status flags come only from the registered count, so wrreq/rdreq
    // cannot reach them combinationally.
    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign usedw = count;

    // A read needs data. A write needs space, or a read that frees a slot
    // in the same cycle. Clear and reset take priority over both.
    assign rd_acc = rdreq && !empty;
    assign wr_acc = wrreq && (!full || rd_acc);

    // Storage has no reset. A flush or reset only moves the pointers.
    always_ff @(posedge clk) begin
        if (reset && !clear && wr_acc) begin
            mem[wr_ptr] <= data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read data path: either the head entry shown directly, or a register
    // loaded on each accepted read.
    generate
        if (SHOWAHEAD != 0) begin : g_show
            assign q = mem[rd_ptr];
        end else begin : g_reg
            logic [WIDTH-1:0] q_reg;

            // Capture the head entry when a read is accepted. Otherwise hold.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    q_reg <= '0;
                end else if (!clear && rd_acc) begin
                    q_reg <= mem[rd_ptr];
                end
            end

            assign q = q_reg;
        end
    endgenerate

`ifdef SYNC_FIFO_STATUS_EN
    localparam logic [DEPTH_LOG2:0] AFULL_CNT = (DEPTH_LOG2 + 1)'(AFULL_LEVEL);

    logic overflow_r;
    logic underflow_r;

    assign almost_full = (count >= AFULL_CNT);
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;

    // Sticky error flags. They are cleared only by reset, not by clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (!clear) begin
            if (wrreq && !wr_acc) begin
                overflow_r <= 1'b1;
            end
            if (rdreq && empty) begin
                underflow_r <= 1'b1;
            end
        end
    end
`else
    assign almost_full = 1'b0;
    assign overflow    = 1'b0;
    assign underflow   = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: drives two 4-entry sync_fifo instances with the same
// stimulus. One uses the registered read mode and one uses show-ahead.
// A queue model tracks the expected contents and status.
module tb_sync_fifo;

`ifdef SYNC_FIFO_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    localparam int DEPTH = 4;
    localparam int AFULL = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] data = '0;
    logic       wrreq = 1'b0;
    logic       rdreq = 1'b0;

    logic [7:0] q_reg, q_sa;
    logic       empty_reg, full_reg, af_reg, ovf_reg, udf_reg;
    logic       empty_sa, full_sa, af_sa, ovf_sa, udf_sa;
    logic [2:0] usedw_reg, usedw_sa;

    int checks = 0;
    int errors = 0;

    logic [7:0] model[$];
    logic [7:0] exp_q;
    bit         m_ovf, m_udf;

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(2), .AFULL_LEVEL(AFULL), .SHOWAHEAD(0)) dut_reg (
        .clk(clk), .reset(reset), .clear(clear), .data(data),
        .wrreq(wrreq), .rdreq(rdreq), .q(q_reg), .empty(empty_reg),
        .full(full_reg), .almost_full(af_reg), .usedw(usedw_reg),
        .overflow(ovf_reg), .underflow(udf_reg)
    );

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(2), .AFULL_LEVEL(AFULL), .SHOWAHEAD(1)) dut_sa (
        .clk(clk), .reset(reset), .clear(clear), .data(data),
        .wrreq(wrreq), .rdreq(rdreq), .q(q_sa), .empty(empty_sa),
        .full(full_sa), .almost_full(af_sa), .usedw(usedw_sa),
        .overflow(ovf_sa), .underflow(udf_sa)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare both instances against the model state.
    task automatic checkAll();
        int n;
        n = model.size();
        checkOutput("usedw_reg", 32'(usedw_reg), 32'(n));
        checkOutput("usedw_sa",  32'(usedw_sa),  32'(n));
        checkOutput("empty_reg", 32'(empty_reg), 32'(n == 0));
        checkOutput("empty_sa",  32'(empty_sa),  32'(n == 0));
        checkOutput("full_reg",  32'(full_reg),  32'(n == DEPTH));
        checkOutput("full_sa",   32'(full_sa),   32'(n == DEPTH));
        checkOutput("afull_reg", 32'(af_reg),    32'(STATUS_EN && n >= AFULL));
        checkOutput("afull_sa",  32'(af_sa),     32'(STATUS_EN && n >= AFULL));
        checkOutput("ovf_reg",   32'(ovf_reg),   32'(STATUS_EN && m_ovf));
        checkOutput("ovf_sa",    32'(ovf_sa),    32'(STATUS_EN && m_ovf));
        checkOutput("udf_reg",   32'(udf_reg),   32'(STATUS_EN && m_udf));
        checkOutput("udf_sa",    32'(udf_sa),    32'(STATUS_EN && m_udf));
        checkOutput("q_reg",     32'(q_reg),     32'(exp_q));
        if (n != 0) begin
            checkOutput("q_sa", 32'(q_sa), 32'(model[0]));
        end
    endtask

    // Drive one cycle of requests, update the model, and check after the edge.
    task automatic applyStimulus(input bit wr, input bit rd, input bit clr, input logic [7:0] d);
        bit m_empty, m_full, rd_acc, wr_acc;
        wrreq = wr;
        rdreq = rd;
        clear = clr;
        data  = d;
        m_empty = (model.size() == 0);
        m_full  = (model.size() == DEPTH);
        @(posedge clk);
        #1;
        if (clr) begin
            model.delete();
        end else begin
            rd_acc = rd && !m_empty;
            wr_acc = wr && (!m_full || rd_acc);
            if (rd_acc) exp_q = model.pop_front();
            if (wr_acc) model.push_back(d);
            if (wr && !wr_acc) m_ovf = 1'b1;
            if (rd && m_empty) m_udf = 1'b1;
        end
        wrreq = 1'b0;
        rdreq = 1'b0;
        clear = 1'b0;
        checkAll();
    endtask

    // Pulse reset low for one cycle and check every output against its reset value.
    task automatic applyReset();
        reset = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        clear = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model.delete();
        exp_q = 8'h00;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        checkAll();
    endtask

    initial begin
        logic [7:0] vals [4];
        logic [7:0] vals2 [4];
        vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
        vals2 = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_q = 8'h00;
        m_ovf = 1'b0;
        m_udf = 1'b0;

        // Reset state.
        applyReset();

        // Fill to full, attempt an overflow, then drain in order.
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, vals[i]);
        applyStimulus(1, 0, 0, 8'h55);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 8'h00);

        // Simultaneous write and read while full.
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, vals[i]);
        applyStimulus(1, 1, 0, 8'h66);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 8'h00);

        // Write and read together while empty: the write lands and the read is rejected.
        applyStimulus(1, 1, 0, 8'hA5);
        applyStimulus(0, 1, 0, 8'h00);

        // Almost-full threshold and the show-ahead head.
        applyReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, vals2[i]);
        applyStimulus(0, 1, 0, 8'h00);

        // Clear dominates a write. The first write after clear lands at the head.
        applyStimulus(1, 0, 0, vals2[3]);
        applyStimulus(1, 0, 0, 8'h77);
        applyStimulus(1, 0, 1, 8'h99);
        applyStimulus(1, 0, 0, 8'hC3);

        // Overflow, then reset mid-stream.
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, vals[i]);
        applyStimulus(1, 0, 0, 8'hEE);
        applyReset();
        applyStimulus(1, 0, 0, 8'h5A);
        applyStimulus(0, 1, 0, 8'h00);

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 29) == 0), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
